// File: rtl/kmeans_centroid_update.sv
// rtl/kmeans_centroid_update.sv - k-means update half: per-cluster accumulate, divide, centroid store
// Optional CONVERGE_DETECT_EN builds the converged flag; otherwise converged is tied low.
module kmeans_centroid_update #(
  parameter int NUM_CLUSTERS = 4,
  parameter int IDX_W        = 2,
  parameter int COORD_W      = 32,
  parameter int CNT_W        = 16,
  parameter int SUM_W        = COORD_W + CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic [IDX_W-1:0]   pt_idx,
  input  logic               epoch_end,
  input  logic               init_we,
  input  logic [IDX_W-1:0]   init_id,
  input  logic [COORD_W-1:0] init_x,
  input  logic [COORD_W-1:0] init_y,
  input  logic [IDX_W-1:0]   rd_id,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_id,
  output logic [COORD_W-1:0] upd_x,
  output logic [COORD_W-1:0] upd_y,
  output logic               busy,
  output logic               done,
  output logic               sat_err,
  output logic               converged
);

  localparam logic [2:0] S_ACCUM = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  // Storage spans the full index space so any rd_id/pt_idx value is a legal index;
  // slots at or above NUM_CLUSTERS are never written and read back as zero.
  localparam int NSLOT = 1 << IDX_W;
  localparam int BIT_W = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_CLUSTERS - 1);

  logic [2:0]         state;
  logic [IDX_W-1:0]   c;
  logic [SUM_W-1:0]   sum_x [NSLOT];
  logic [SUM_W-1:0]   sum_y [NSLOT];
  logic [CNT_W-1:0]   cnt   [NSLOT];
  logic [COORD_W-1:0] cen_x [NSLOT];
  logic [COORD_W-1:0] cen_y [NSLOT];
  logic [SUM_W-1:0]   dq_x, dq_y;
  logic [CNT_W-1:0]   rem_x, rem_y, dvs;
  logic [BIT_W-1:0]   bitn;

  logic [CNT_W:0]     tx, ty;
  logic [CNT_W-1:0]   dx, dy;
  logic               ge_x, ge_y, idx_ok;

  // dq holds the shifting dividend; quotient bits enter at the LSB end
  always_comb begin
    tx   = {rem_x, dq_x[SUM_W-1]};
    ty   = {rem_y, dq_y[SUM_W-1]};
    ge_x = tx >= {1'b0, dvs};
    ge_y = ty >= {1'b0, dvs};
    dx   = tx[CNT_W-1:0] - dvs;
    dy   = ty[CNT_W-1:0] - dvs;
  end

  assign idx_ok   = {1'b0, pt_idx} < (IDX_W + 1)'(NUM_CLUSTERS);
  assign pt_ready = (state == S_ACCUM);
  assign busy     = (state != S_ACCUM);
  assign done     = (state == S_NEXT) && (c == LAST);
  assign rd_x     = cen_x[rd_id];
  assign rd_y     = cen_y[rd_id];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_ACCUM;
      c         <= '0;
      bitn      <= '0;
      dq_x      <= '0;
      dq_y      <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      dvs       <= '0;
      upd_valid <= 1'b0;
      upd_id    <= '0;
      upd_x     <= '0;
      upd_y     <= '0;
      sat_err   <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
        cnt[i]   <= '0;
        cen_x[i] <= '0;
        cen_y[i] <= '0;
      end
    end else begin
      upd_valid <= 1'b0;
      case (state)
        S_ACCUM: begin
          if (pt_valid && idx_ok) begin
            if (cnt[pt_idx] == CNT_MAX) begin
              sat_err <= 1'b1;
            end else begin
              sum_x[pt_idx] <= sum_x[pt_idx] + SUM_W'(pt_x);
              sum_y[pt_idx] <= sum_y[pt_idx] + SUM_W'(pt_y);
              cnt[pt_idx]   <= cnt[pt_idx] + 1'b1;
            end
          end
          if (init_we) begin
            cen_x[init_id] <= init_x;
            cen_y[init_id] <= init_y;
          end
          if (epoch_end) begin
            state <= S_LOAD;
            c     <= '0;
          end
        end
        S_LOAD: begin
          dq_x  <= sum_x[c];
          dq_y  <= sum_y[c];
          rem_x <= '0;
          rem_y <= '0;
          dvs   <= cnt[c];
          bitn  <= '0;
          state <= (cnt[c] == '0) ? S_NEXT : S_DIV;
        end
        S_DIV: begin
          dq_x  <= {dq_x[SUM_W-2:0], ge_x};
          dq_y  <= {dq_y[SUM_W-2:0], ge_y};
          rem_x <= ge_x ? dx : tx[CNT_W-1:0];
          rem_y <= ge_y ? dy : ty[CNT_W-1:0];
          bitn  <= bitn + 1'b1;
          if (bitn == BIT_W'(SUM_W - 1)) state <= S_WRITE;
        end
        S_WRITE: begin
          cen_x[c]  <= dq_x[COORD_W-1:0];
          cen_y[c]  <= dq_y[COORD_W-1:0];
          upd_valid <= 1'b1;
          upd_id    <= c;
          upd_x     <= dq_x[COORD_W-1:0];
          upd_y     <= dq_y[COORD_W-1:0];
          state     <= S_NEXT;
        end
        S_NEXT: begin
          if (c == LAST) begin
            for (int i = 0; i < NSLOT; i++) begin
              sum_x[i] <= '0;
              sum_y[i] <= '0;
              cnt[i]   <= '0;
            end
            state <= S_ACCUM;
          end else begin
            c     <= c + 1'b1;
            state <= S_LOAD;
          end
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

`ifdef CONVERGE_DETECT_EN
  logic conv_q, changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_q  <= 1'b0;
      changed <= 1'b0;
    end else if (state == S_ACCUM && epoch_end) begin
      conv_q  <= 1'b0;
      changed <= 1'b0;
    end else if (state == S_WRITE) begin
      if (dq_x[COORD_W-1:0] != cen_x[c] || dq_y[COORD_W-1:0] != cen_y[c]) changed <= 1'b1;
    end else if (done) begin
      conv_q <= ~changed;
    end
  end

  assign converged = conv_q;
`else
  assign converged = 1'b0;
`endif

endmodule

// File: doc/kmeans_centroid_update.md
Name: kmeans_centroid_update

Overview:
- Update half of the k-means loop.
- Consumes the point/cluster-index stream produced by the assignment block (point coordinates plus the winning cluster index) and accumulates per-cluster coordinate sums and counts.
- On an epoch-end request it divides each sum by its count to produce new centroids, writes them to an internal centroid register file, and streams each update out.
- The assignment block reads the stored centroids back through the combinational read port for the next epoch.

Parameters:
- NUM_CLUSTERS, 4, number of clusters (must be ≤ 2**IDX_W)
- IDX_W, 2, cluster index width
- COORD_W, 32, unsigned coordinate width
- CNT_W, 16, per-cluster point counter width
- SUM_W, COORD_W+CNT_W (48), accumulator width; overflow-free by construction

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pt_valid  in  1  point/index pair valid
- pt_ready  out  1  block can accept a point
- pt_x  in  COORD_W  point x
- pt_y  in  COORD_W  point y
- pt_idx  in  IDX_W  assigned cluster index
- epoch_end  in  1  single-cycle request to compute new centroids
- init_we  in  1  centroid seed write enable
- init_id  in  IDX_W  seed cluster id
- init_x  in  COORD_W  seed x
- init_y  in  COORD_W  seed y
- rd_id  in  IDX_W  centroid read select
- rd_x  out  COORD_W  stored centroid x for rd_id (combinational)
- rd_y  out  COORD_W  stored centroid y for rd_id (combinational)
- upd_valid  out  1  one-cycle pulse: centroid upd_id was just written
- upd_id  out  IDX_W  updated cluster id
- upd_x  out  COORD_W  new centroid x
- upd_y  out  COORD_W  new centroid y
- busy  out  1  update in progress
- done  out  1  one-cycle pulse when all clusters have been processed
- sat_err  out  1  sticky: a point was dropped because its cluster counter was saturated
- converged  out  1  see Optional Feature

Behaviour:
- Reset clears all of the following and forces state ACCUM:
  - all sums, counts and centroid registers (to 0)
  - upd_valid, upd_id, upd_x, upd_y, busy, done, sat_err, converged
  - after reset, pt_ready=1.
- Reset asserted mid-division aborts the division immediately; no upd_valid or done is produced.

States:
- ACCUM:
  - pt_ready=1.
  - A point is accepted when pt_valid&&pt_ready; its sums and count update on that edge.
  - pt_idx ≥ NUM_CLUSTERS: point ignored, nothing updated.
  - Count already at 2**CNT_W-1: point dropped; sat_err set until reset.
  - init_we writes centroid[init_id] (x,y) on that edge; init_we is ignored in all other states.
  - epoch_end -> LOAD, cluster pointer c=0.
  - A point accepted in the same cycle as epoch_end belongs to the closing epoch.
- LOAD:
  - pt_ready=0, busy=1 (busy stays 1 until done).
  - count[c]==0: centroid unchanged; go to NEXT (no upd_valid).
  - Otherwise: start two parallel restoring dividers (sum_x/count, sum_y/count); go to DIV.
- DIV:
  - One quotient bit per cycle, MSB first; SUM_W cycles.
  - Quotient truncates toward zero; low COORD_W bits are kept (the upper bits are provably zero).
  - Then -> WRITE.
- WRITE:
  - centroid[c] is written.
  - The next cycle has upd_valid=1 with upd_id=c and upd_x/upd_y = the new values.
  - -> NEXT.
- NEXT:
  - If c==NUM_CLUSTERS-1: done=1 for one cycle, all sums and counts cleared, -> ACCUM.
  - Else c+1 -> LOAD.
- epoch_end outside ACCUM is ignored.

Latency and outputs:
- Non-empty cluster: 1 LOAD + SUM_W DIV + 1 WRITE + 1 NEXT = SUM_W+3 cycles.
- Empty cluster: 2 cycles.
- rd_x/rd_y reflect a write the cycle after it.
- upd_x/upd_y hold their last values between pulses.

Optional Feature:
- Macro: CONVERGE_DETECT_EN.
- Defined:
  - converged is cleared at entry to LOAD for c=0.
  - It is set at done if no WRITE during the pass changed a centroid value.
  - An all-empty pass counts as converged.
  - converged holds its value until the next epoch_end is accepted.
- Undefined: converged is tied to 0 and no comparison logic is built.

Test Plan:
- Seed/readback: init_we id=2 (100,200) -> rd_id=2 gives rd_x=100, rd_y=200 next cycle; all other ids read 0.
- Basic update: points (10,20),(30,40),(20,60) on idx 1, then epoch_end -> single upd_valid, id=1, (20,40); done pulses exactly 2+2+51+2 cycles after epoch_end for clusters 0,2,3 empty.
- Truncation/empty keep:
  - Seed id0=(7,7); points (1,2),(2,2) on idx 3.
  - After epoch_end: id3 -> (1,2), no upd for id0, rd id0 stays (7,7).
- Back-pressure/simultaneity:
  - pt_ready=0 throughout the update.
  - A point presented with epoch_end is included in that epoch.
  - Points held valid during busy are accepted after done into the next epoch.
  - Second epoch sums start from 0.
- Saturation and reset: with CNT_W=2, 4 points on idx0 -> 4th dropped, sat_err=1, centroid = mean of the first 3; reset asserted mid-DIV -> no upd_valid, all outputs 0, pt_ready=1 next cycle.
- CONVERGE_DETECT_EN: repeat an identical epoch -> converged=1 after the second done; change one point -> converged=0.
